// File: rtl/ringbuf_ro_sched.sv
// Ring-buffer readout scheduler: freezes write pointer on trigger,
// walks each channel's window and streams words to the SPI link.
module ringbuf_ro_sched #(
  parameter int SIZE = 12,
  parameter int NCH  = 4,
  parameter int CHW  = 2,
  parameter int DW   = 16
) (
  input  logic            sysclk,
  input  logic            rst,
  input  logic            trig_i,
  input  logic [SIZE-1:0] wr_ptr_i,
  input  logic [SIZE-1:0] offset_i,
  input  logic [SIZE-1:0] howmany_i,
  output logic            freeze_o,
  output logic            rd_en_o,
  output logic [SIZE-1:0] rd_addr_o,
  output logic [CHW-1:0]  rd_ch_o,
  input  logic [DW-1:0]   ram_q_i,
  output logic            spi_valid_o,
  input  logic            spi_ready_i,
  output logic [DW-1:0]   spi_word_o,
  output logic            spi_last_o,
  output logic            done_o,
  output logic            trig_drop_o
);

  typedef enum logic [2:0] {
    IDLE, ADDR, CAPT, XFER, FIN
  } state_t;

  localparam logic [CHW-1:0] LAST_CH = CHW'(NCH - 1);

  state_t          state;
  logic [SIZE-1:0] start_q;
  logic [SIZE-1:0] hm_q;
  logic [SIZE-1:0] widx;
  logic [CHW-1:0]  ch;
  logic            last_word;
  logic            last_ch;

  // End-of-window flags for the word currently being handled
  always_comb begin
    last_word = (widx == hm_q - SIZE'(1));
    last_ch   = (ch == LAST_CH);
  end

  // Readout sequencer; every output is a register set on state entry
  always_ff @(posedge sysclk) begin
    if (rst) begin
      state       <= IDLE;
      start_q     <= '0;
      hm_q        <= '0;
      widx        <= '0;
      ch          <= '0;
      freeze_o    <= 1'b0;
      rd_en_o     <= 1'b0;
      rd_addr_o   <= '0;
      rd_ch_o     <= '0;
      spi_valid_o <= 1'b0;
      spi_word_o  <= '0;
      spi_last_o  <= 1'b0;
      done_o      <= 1'b0;
      trig_drop_o <= 1'b0;
    end else begin
      rd_en_o     <= 1'b0;
      rd_addr_o   <= '0;
      done_o      <= 1'b0;
      trig_drop_o <= trig_i && (state != IDLE);
      unique case (state)
        IDLE: begin
          if (trig_i) begin
            start_q  <= wr_ptr_i - offset_i - howmany_i;
            hm_q     <= howmany_i;
            widx     <= '0;
            ch       <= '0;
            freeze_o <= 1'b1;
            if (howmany_i == '0) begin
              state <= FIN;
            end else begin
              state     <= ADDR;
              rd_en_o   <= 1'b1;
              rd_addr_o <= wr_ptr_i - offset_i - howmany_i;
              rd_ch_o   <= '0;
            end
          end
        end
        ADDR: begin
          state <= CAPT;
        end
        CAPT: begin
          spi_word_o  <= ram_q_i;
          spi_valid_o <= 1'b1;
          spi_last_o  <= last_ch && last_word;
          state       <= XFER;
        end
        XFER: begin
          if (spi_ready_i) begin
            spi_valid_o <= 1'b0;
            spi_last_o  <= 1'b0;
            if (!last_word) begin
              widx      <= widx + SIZE'(1);
              rd_en_o   <= 1'b1;
              rd_addr_o <= start_q + widx + SIZE'(1);
              rd_ch_o   <= ch;
              state     <= ADDR;
            end else if (!last_ch) begin
              ch        <= ch + CHW'(1);
              widx      <= '0;
              rd_en_o   <= 1'b1;
              rd_addr_o <= start_q;
              rd_ch_o   <= ch + CHW'(1);
              state     <= ADDR;
            end else begin
              state <= FIN;
            end
          end
        end
        FIN: begin
          done_o   <= 1'b1;
          freeze_o <= 1'b0;
          state    <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
